// File: rtl/spi_ram_burst.sv
// spi_ram_burst
//   Command-decoding RAM between the SPI slave deserializer and serializer.
//   Each frame on din carries a 2-bit command and a payload. Independent write
//   and read pointers with optional post-increment and wrap at MEM_DEPTH-1.
//   Illegal frames produce a one-cycle err pulse and change no state.
//
// Ports
//   clk       clock
//   rst_n     asynchronous active-low reset
//   din       frame: [PW+1:PW] command, [PW-1:0] payload
//   rx_valid  frame valid, din is ignored when low
//   dout      read data, held until the next read result
//   tx_valid  one-cycle pulse, dout is new
//   err       one-cycle pulse, the previous frame was rejected
//
// Commands: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA
module spi_ram_burst #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int MEM_DEPTH    = 256,
    parameter int AUTO_INC     = 1,
    parameter int READ_LATENCY = 1,
    localparam int PW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PW+1:0]         din,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  tx_valid,
    output logic                  err
);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_DEPTH - 1);

    logic [1:0]            cmd;
    logic [ADDR_WIDTH-1:0] pl_addr;
    logic [DATA_WIDTH-1:0] pl_data;
    logic                  addr_ok;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_armed;
    logic                  rd_armed;

    logic                  wr_fire;
    logic                  rd_fire;
    logic                  reject;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;

    assign cmd     = din[PW+1:PW];
    assign pl_addr = din[ADDR_WIDTH-1:0];
    assign pl_data = din[DATA_WIDTH-1:0];
    assign addr_ok = {1'b0, pl_addr} < DEPTH_X;

    assign wr_fire = rx_valid && (cmd == CMD_WR_DATA) && wr_armed;
    assign rd_fire = rx_valid && (cmd == CMD_RD_DATA) && rd_armed;

    always_comb begin
        reject = 1'b0;
        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: reject = !addr_ok;
                CMD_WR_DATA: reject = !wr_armed;
                CMD_RD_ADDR: reject = !addr_ok;
                default:     reject = !rd_armed;
            endcase
        end
    end

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_armed <= 1'b0;
            rd_armed <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= reject;
            if (rx_valid && !reject) begin
                case (cmd)
                    CMD_WR_ADDR: begin
                        wr_ptr   <= pl_addr;
                        wr_armed <= 1'b1;
                    end
                    CMD_WR_DATA: if (AUTO_INC != 0) wr_ptr <= ptr_inc(wr_ptr);
                    CMD_RD_ADDR: begin
                        rd_ptr   <= pl_addr;
                        rd_armed <= 1'b1;
                    end
                    default:     if (AUTO_INC != 0) rd_ptr <= ptr_inc(rd_ptr);
                endcase
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= pl_data;
    end

    assign rd_word = mem[rd_ptr];

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s1_valid;
            logic [DATA_WIDTH-1:0] s1_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    tx_valid <= 1'b0;
                    dout     <= '0;
                end else begin
                    s1_valid <= rd_fire;
                    if (rd_fire) s1_data <= rd_word;
                    tx_valid <= s1_valid;
                    if (s1_valid) dout <= s1_data;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tx_valid <= 1'b0;
                    dout     <= '0;
                end else begin
                    tx_valid <= rd_fire;
                    if (rd_fire) dout <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_spi_ram_burst.sv
module tb_spi_ram_burst;

    logic       clk = 1'b0;
    logic       rstn  [3];
    logic [9:0] din_a [3];
    logic       rxv   [3];
    logic [7:0] dout_a[3];
    logic       txv   [3];
    logic       err_a [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // dut0: defaults; dut1: 200-word memory; dut2: latency 2, no auto-increment
    spi_ram_burst u_dut0 (
        .clk(clk), .rst_n(rstn[0]), .din(din_a[0]), .rx_valid(rxv[0]),
        .dout(dout_a[0]), .tx_valid(txv[0]), .err(err_a[0]));

    spi_ram_burst #(.MEM_DEPTH(200)) u_dut1 (
        .clk(clk), .rst_n(rstn[1]), .din(din_a[1]), .rx_valid(rxv[1]),
        .dout(dout_a[1]), .tx_valid(txv[1]), .err(err_a[1]));

    spi_ram_burst #(.READ_LATENCY(2), .AUTO_INC(0)) u_dut2 (
        .clk(clk), .rst_n(rstn[2]), .din(din_a[2]), .rx_valid(rxv[2]),
        .dout(dout_a[2]), .tx_valid(txv[2]), .err(err_a[2]));

    // Behavioural reference for dut0: the RAM as an array plus two pointers.
    bit [7:0] m_mem   [256];
    bit       m_known [256];
    int       m_wp, m_rp;
    bit       m_wa, m_ra;
    bit       m_err, m_tx, m_dknown;
    bit [7:0] m_dout;

    function automatic void model_reset();
        m_wp = 0; m_rp = 0; m_wa = 0; m_ra = 0;
        m_err = 0; m_tx = 0; m_dout = 0; m_dknown = 1;
    endfunction

    function automatic void model_edge(bit v, bit [1:0] c, bit [7:0] p);
        m_err = 0;
        m_tx  = 0;
        if (!v) return;
        case (c)
            2'd0: begin m_wp = p; m_wa = 1; end
            2'd1: if (!m_wa) m_err = 1;
                  else begin
                      m_mem[m_wp] = p; m_known[m_wp] = 1;
                      m_wp = (m_wp + 1) % 256;
                  end
            2'd2: begin m_rp = p; m_ra = 1; end
            default: if (!m_ra) m_err = 1;
                  else begin
                      m_tx = 1; m_dout = m_mem[m_rp]; m_dknown = m_known[m_rp];
                      m_rp = (m_rp + 1) % 256;
                  end
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one frame at the falling edge; returns 1ns after the sampling edge.
    task automatic step(int k, bit v, bit [1:0] c, bit [7:0] p);
        @(negedge clk);
        din_a[k] = {c, p};
        rxv[k]   = v;
        @(posedge clk);
        if (k == 0) model_edge(v, c, p);
        #1;
    endtask

    typedef struct {
        bit       v;
        bit [1:0] c;
        bit [7:0] p;
        bit       e_err;
        bit       e_tx;
        bit [7:0] e_dout;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit v, bit [1:0] c, bit [7:0] p, bit e, bit t, bit [7:0] d);
        vec_t x;
        x.v = v; x.c = c; x.p = p; x.e_err = e; x.e_tx = t; x.e_dout = d;
        tbl.push_back(x);
    endfunction

    initial begin
        // unarmed commands, burst write/read, wrap-around, independent pointers
        add(1, 3, 8'h00, 1, 0, 8'h00);
        add(1, 1, 8'h77, 1, 0, 8'h00);
        add(1, 0, 8'h10, 0, 0, 8'h00);
        add(1, 1, 8'hA1, 0, 0, 8'h00);
        add(1, 1, 8'hA2, 0, 0, 8'h00);
        add(1, 1, 8'hA3, 0, 0, 8'h00);
        add(1, 2, 8'h10, 0, 0, 8'h00);
        add(1, 3, 8'h00, 0, 1, 8'hA1);
        add(1, 3, 8'h5C, 0, 1, 8'hA2);
        add(1, 3, 8'h00, 0, 1, 8'hA3);
        add(0, 3, 8'h00, 0, 0, 8'hA3);
        add(1, 0, 8'hFF, 0, 0, 8'hA3);
        add(1, 1, 8'h55, 0, 0, 8'hA3);
        add(1, 1, 8'h66, 0, 0, 8'hA3);
        add(1, 2, 8'hFF, 0, 0, 8'hA3);
        add(1, 3, 8'h00, 0, 1, 8'h55);
        add(1, 3, 8'h00, 0, 1, 8'h66);
        add(0, 1, 8'h12, 0, 0, 8'h66);
        add(1, 1, 8'h99, 0, 0, 8'h66);
        add(1, 3, 8'h00, 0, 1, 8'h99);

        for (int k = 0; k < 3; k++) begin
            rstn[k] = 1'b0; din_a[k] = '0; rxv[k] = 1'b0;
        end
        model_reset();
        for (int i = 0; i < 256; i++) m_known[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_tx%0d", k), 32'(txv[k]), 0);
            chk($sformatf("rst_err%0d", k), 32'(err_a[k]), 0);
            chk($sformatf("rst_dout%0d", k), 32'(dout_a[k]), 0);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rstn[k] = 1'b1;

        // idle with toggling din must not change anything
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 2'($urandom_range(0, 3)), 8'($urandom));
            chk("idle_tx", 32'(txv[0]), 0);
            chk("idle_err", 32'(err_a[0]), 0);
            chk("idle_dout", 32'(dout_a[0]), 0);
        end

        foreach (tbl[i]) begin
            step(0, tbl[i].v, tbl[i].c, tbl[i].p);
            chk($sformatf("tbl%0d_err", i), 32'(err_a[0]), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_tx", i), 32'(txv[0]), 32'(tbl[i].e_tx));
            chk($sformatf("tbl%0d_dout", i), 32'(dout_a[0]), 32'(tbl[i].e_dout));
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            bit       v;
            bit [1:0] c;
            bit [7:0] p;
            v = ($urandom_range(0, 9) != 0);
            c = 2'($urandom_range(0, 3));
            p = (c == 2'd0 || c == 2'd2) ? 8'($urandom_range(0, 24) + 8'hF0) : 8'($urandom);
            step(0, v, c, p);
            chk("rnd_err", 32'(err_a[0]), 32'(m_err));
            chk("rnd_tx", 32'(txv[0]), 32'(m_tx));
            if (m_dknown) chk("rnd_dout", 32'(dout_a[0]), 32'(m_dout));
        end

        // out-of-range addresses on a 200-word memory
        step(1, 1, 0, 8'hC8);
        chk("oor_wa_err", 32'(err_a[1]), 1);
        step(1, 1, 1, 8'h33);
        chk("oor_unarmed_err", 32'(err_a[1]), 1);
        step(1, 1, 0, 8'hC7);
        chk("oor_c7_err", 32'(err_a[1]), 0);
        step(1, 1, 1, 8'h11);
        step(1, 1, 1, 8'h22);
        step(1, 1, 2, 8'hFF);
        chk("oor_ra_err", 32'(err_a[1]), 1);
        step(1, 1, 3, 8'h00);
        chk("oor_rd_unarmed", 32'(err_a[1]), 1);
        chk("oor_rd_unarmed_tx", 32'(txv[1]), 0);
        step(1, 1, 2, 8'hC7);
        step(1, 1, 3, 8'h00);
        chk("wrap199_tx", 32'(txv[1]), 1);
        chk("wrap199_dout", 32'(dout_a[1]), 8'h11);
        step(1, 1, 3, 8'h00);
        chk("wrap0_tx", 32'(txv[1]), 1);
        chk("wrap0_dout", 32'(dout_a[1]), 8'h22);
        chk("wrap0_err", 32'(err_a[1]), 0);
        step(1, 0, 0, 8'h00);

        // latency 2, no increment: back-to-back reads of one address
        step(2, 1, 0, 8'h20);
        step(2, 1, 1, 8'h3C);
        step(2, 1, 1, 8'h5A);
        step(2, 1, 2, 8'h20);
        step(2, 1, 3, 8'h00);
        chk("l2_e0_tx", 32'(txv[2]), 0);
        step(2, 1, 3, 8'h00);
        chk("l2_e1_tx", 32'(txv[2]), 1);
        chk("l2_e1_dout", 32'(dout_a[2]), 8'h5A);
        step(2, 0, 0, 8'h00);
        chk("l2_e2_tx", 32'(txv[2]), 1);
        chk("l2_e2_dout", 32'(dout_a[2]), 8'h5A);
        step(2, 0, 0, 8'h00);
        chk("l2_e3_tx", 32'(txv[2]), 0);
        chk("l2_e3_dout", 32'(dout_a[2]), 8'h5A);

        // reset while a read is in flight
        step(2, 1, 3, 8'h00);
        @(negedge clk);
        rxv[2]  = 1'b0;
        rstn[2] = 1'b0;
        #1;
        chk("rstmid_tx", 32'(txv[2]), 0);
        chk("rstmid_dout", 32'(dout_a[2]), 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("rstmid_no_tx", 32'(txv[2]), 0);
            chk("rstmid_dout0", 32'(dout_a[2]), 0);
            if (i == 2) begin
                @(negedge clk);
                rstn[2] = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
